// File: rtl/num_sender_pkg.sv
// Shared types and widths for the num_frame_sender host driver and its operand buffer.
package num_sender_pkg;

  localparam int NUM_W  = 4;
  localparam int MODE_W = 2;
  localparam int RES_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/num_fifo.sv
// Operand buffer: strict FIFO with power-of-two depth and free-running wrapping pointers.
module num_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/num_frame_sender.sv
// Host-side frame sender/collector for the lab06_2 compute interface.
// Define NUM_SENDER_TIMEOUT_EN to add the WAIT-state watchdog abort.
//
// state | meaning
// IDLE  | waiting for a host start with enough buffered operands
// SEND  | driving FRAME_LEN beats of in_valid/in_number
// WAIT  | waiting for out_valid (or watchdog expiry)
// RESP  | holding res_valid until the host takes the result
module num_frame_sender
  import num_sender_pkg::*;
#(
  parameter int FRAME_LEN  = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [NUM_W-1:0]  wr_number,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [MODE_W-1:0] start_mode,
  output logic              in_valid,
  output logic [NUM_W-1:0]  in_number,
  output logic [MODE_W-1:0] mode,
  input  logic              out_valid,
  input  logic [RES_W-1:0]  out_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_timeout,
  output logic              busy
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = $clog2(FRAME_LEN + 1);

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               in_valid_q, in_valid_d;
  logic [NUM_W-1:0]   in_number_q, in_number_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               res_valid_q, res_valid_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic               res_timeout_q, res_timeout_d;

  logic               push, pop, start_fire, beat_last, wdog_expire;
  logic [NUM_W-1:0]   head;
  logic [CNT_W-1:0]   fifo_cnt;

  num_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(NUM_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (wr_number),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign wr_ready    = fifo_cnt < CNT_W'(FIFO_DEPTH);
  assign push        = wr_valid && wr_ready;
  assign start_ready = (state_q == IDLE) && (fifo_cnt >= CNT_W'(FRAME_LEN));
  assign start_fire  = start_valid && start_ready;
  assign beat_last   = beat_q == BEAT_W'(FRAME_LEN);

`ifdef NUM_SENDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wdog_q;

  // Loaded as WAIT is entered; expiry fires on the TIMEOUT-th WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                wdog_q <= '0;
    else if (state_q == SEND && beat_last)  wdog_q <= TO_W'(TIMEOUT);
    else if (state_q == WAIT && wdog_q != '0) wdog_q <= wdog_q - 1'b1;
  end

  assign wdog_expire = (state_q == WAIT) && (wdog_q == TO_W'(1));
`else
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_fire) state_d = SEND;
      SEND:    if (beat_last) state_d = WAIT;
      WAIT:    if (out_valid || wdog_expire) state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat 0 is popped on the accepting edge so in_valid rises the cycle after start.
  always_comb begin
    beat_d        = beat_q;
    in_valid_d    = 1'b0;
    in_number_d   = '0;
    mode_d        = '0;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    pop           = 1'b0;
    case (state_q)
      IDLE: if (start_fire) begin
        pop         = 1'b1;
        in_valid_d  = 1'b1;
        in_number_d = head;
        mode_d      = start_mode;
        beat_d      = BEAT_W'(1);
      end
      SEND: if (!beat_last) begin
        pop         = 1'b1;
        in_valid_d  = 1'b1;
        in_number_d = head;
        beat_d      = beat_q + 1'b1;
      end
      WAIT: if (out_valid) begin
        res_valid_d   = 1'b1;
        res_data_d    = out_result;
        res_timeout_d = 1'b0;
      end else if (wdog_expire) begin
        res_valid_d   = 1'b1;
        res_data_d    = '0;
        res_timeout_d = 1'b1;
      end
      RESP: if (res_ready) res_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q        <= '0;
      in_valid_q    <= 1'b0;
      in_number_q   <= '0;
      mode_q        <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      beat_q        <= beat_d;
      in_valid_q    <= in_valid_d;
      in_number_q   <= in_number_d;
      mode_q        <= mode_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign in_valid    = in_valid_q;
  assign in_number   = in_number_q;
  assign mode        = mode_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign busy        = state_q != IDLE;

endmodule

// File: tb/tb_num_frame_sender.sv
// Directed-plus-random bench for num_frame_sender with a queue model of the operand buffer.
module tb_num_frame_sender;
  import num_sender_pkg::*;

  localparam int L  = 6;
  localparam int D  = 8;
  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid, wr_ready;
  logic [NUM_W-1:0]  wr_number;
  logic              start_valid, start_ready;
  logic [MODE_W-1:0] start_mode;
  logic              in_valid;
  logic [NUM_W-1:0]  in_number;
  logic [MODE_W-1:0] mode;
  logic              out_valid;
  logic [RES_W-1:0]  out_result;
  logic              res_valid, res_ready;
  logic [RES_W-1:0]  res_data;
  logic              res_timeout, busy;

  num_frame_sender #(.FRAME_LEN(L), .FIFO_DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_number(wr_number),
    .start_valid(start_valid), .start_ready(start_ready), .start_mode(start_mode),
    .in_valid(in_valid), .in_number(in_number), .mode(mode),
    .out_valid(out_valid), .out_result(out_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [NUM_W-1:0] q[$];   // expected operand buffer contents, head first

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock edge with the model updated: pop (if any) then accepted push.
  task automatic step(input bit do_pop, output logic [NUM_W-1:0] popped);
    bit acc;
    logic [NUM_W-1:0] num;
    chk("wr_ready", wr_ready, q.size() < D);
    acc    = wr_valid && (q.size() < D);
    num    = wr_number;
    popped = '0;
    if (do_pop) popped = q.pop_front();
    if (acc) q.push_back(num);
    tick();
  endtask

  task automatic push_rand(input int n);
    logic [NUM_W-1:0] dummy;
    for (int i = 0; i < n; i++) begin
      wr_valid  = 1'b1;
      wr_number = NUM_W'($urandom_range(15));
      step(1'b0, dummy);
    end
    wr_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [MODE_W-1:0] m, input bit push_during);
    logic [NUM_W-1:0] exp_num, nxt;
    chk("start_ready_idle", start_ready, q.size() >= L);
    start_valid = 1'b1;
    start_mode  = m;
    step(1'b1, exp_num);
    start_valid = 1'b0;
    start_mode  = MODE_W'($urandom_range(3));
    for (int b = 0; b < L; b++) begin
      chk("in_valid_beat", in_valid, 1);
      chk("in_number_beat", in_number, exp_num);
      chk("mode_beat", mode, (b == 0) ? m : 0);
      chk("start_ready_send", start_ready, 0);
      chk("busy_send", busy, 1);
      out_valid  = (b == 1);            // stray pulse outside WAIT
      out_result = 7'h55;
      wr_valid   = push_during;
      wr_number  = NUM_W'($urandom_range(15));
      step(b < L - 1, nxt);
      exp_num = nxt;
    end
    wr_valid  = 1'b0;
    out_valid = 1'b0;
    chk("in_valid_end", in_valid, 0);
    chk("in_number_end", in_number, 0);
    chk("mode_end", mode, 0);
    chk("busy_wait", busy, 1);
    chk("res_valid_wait", res_valid, 0);
  endtask

  task automatic finish_resp(input logic [RES_W-1:0] exp_data, input logic exp_to, input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("res_valid_hold", res_valid, 1);
      chk("res_data_hold", res_data, exp_data);
      chk("res_timeout_hold", res_timeout, exp_to);
    end
    res_ready = 1'b1;
    chk("start_ready_resp", start_ready, 0);
    tick();
    res_ready = 1'b0;
    chk("res_valid_after_hs", res_valid, 0);
    chk("busy_after_hs", busy, 0);
  endtask

  task automatic collect(input int delay, input logic [RES_W-1:0] r, input int hold);
    for (int d = 0; d < delay; d++) tick();
    chk("res_valid_pre", res_valid, 0);
    out_valid  = 1'b1;
    out_result = r;
    tick();
    out_valid  = 1'b0;
    out_result = RES_W'($urandom);
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, r);
    chk("res_timeout", res_timeout, 0);
    finish_resp(r, 1'b0, hold);
  endtask

  initial begin
    logic [NUM_W-1:0] dummy;
    logic [NUM_W-1:0] vals [6];
    rst = 1'b1; wr_valid = 0; wr_number = 0; start_valid = 0; start_mode = 0;
    out_valid = 0; out_result = 0; res_ready = 0;
    vals = '{4'd3, 4'd5, 4'd7, 4'd1, 4'd0, 4'd15};
    repeat (2) tick();
    rst = 1'b0;

    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_start_ready", start_ready, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_in_number", in_number, 0);
    chk("rst_mode", mode, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_timeout", res_timeout, 0);
    chk("rst_busy", busy, 0);

    // Directed frame: -17 returned two cycles into WAIT, host stalls 10 cycles.
    foreach (vals[i]) begin
      wr_valid = 1'b1; wr_number = vals[i];
      step(1'b0, dummy);
    end
    wr_valid = 1'b0;
    send_frame(2'd2, 1'b0);
    collect(2, 7'b1101111, 10);

    // Five operands are not enough to start.
    push_rand(5);
    start_valid = 1'b1; start_mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("short_start_ready", start_ready, 0);
      chk("short_in_valid", in_valid, 0);
      chk("short_busy", busy, 0);
    end
    push_rand(1);
    send_frame(2'd1, 1'b0);
    collect($urandom_range(5), RES_W'($urandom), $urandom_range(4));

    // Fill, refuse pushes when full, push through SEND, send the wrapped remainder.
    push_rand(D);
    wr_valid = 1'b1; wr_number = 4'hA;
    step(1'b0, dummy);
    step(1'b0, dummy);
    wr_valid = 1'b0;
    send_frame(MODE_W'($urandom_range(3)), 1'b1);
    collect($urandom_range(5), RES_W'($urandom), $urandom_range(4));
    send_frame(MODE_W'($urandom_range(3)), 1'b0);
    collect($urandom_range(5), RES_W'($urandom), $urandom_range(4));

    // No response from the compute block.
    push_rand(L - q.size());
    send_frame(MODE_W'($urandom_range(3)), 1'b0);
`ifdef NUM_SENDER_TIMEOUT_EN
    repeat (TO - 1) tick();
    chk("to_res_valid_early", res_valid, 0);
    tick();
    chk("to_res_valid", res_valid, 1);
    chk("to_res_timeout", res_timeout, 1);
    chk("to_res_data", res_data, 0);
    finish_resp(7'd0, 1'b1, 3);
`else
    repeat (1000) tick();
    chk("nto_busy", busy, 1);
    chk("nto_res_valid", res_valid, 0);
    collect(0, RES_W'($urandom), 2);
`endif

    // Reset on beat 3 discards the frame and the buffer.
    push_rand(L - q.size());
    start_valid = 1'b1; start_mode = 2'd3;
    step(1'b1, dummy);
    start_valid = 1'b0;
    repeat (3) tick();
    chk("mid_in_valid", in_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_in_valid", in_valid, 0);
    chk("arst_in_number", in_number, 0);
    chk("arst_mode", mode, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start_ready", start_ready, 0);
    chk("arst_wr_ready", wr_ready, 1);
    q.delete();
    #1 rst = 1'b0;
    tick();
    out_valid = 1'b1; out_result = RES_W'($urandom);
    tick();
    out_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_res_valid", res_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_start_ready", start_ready, 0);
    end
    push_rand(L);
    send_frame(MODE_W'($urandom_range(3)), 1'b0);
    collect($urandom_range(5), RES_W'($urandom), $urandom_range(4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
